// File: rtl/sync_pkg.sv
// Shared types and default parameter values for the disciplined system-time keeper.
package sync_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_TRACK = 2'd2
    } sync_state_e;

    localparam int DEF_TIME_W      = 64;
    localparam int DEF_PERIOD_W    = 24;
    localparam int DEF_ERR_W       = 16;
    localparam int DEF_ADJ_SPACING = 256;
    localparam int DEF_JUMP_THRESH = 64;
    localparam int DEF_LOCK_THRESH = 1;
    localparam int DEF_LOCK_COUNT  = 8;

endpackage

// File: rtl/sync_edge_detect.sv
// Two-flop synchroniser for the asynchronous sync input, followed by a rising-edge
// detector. The pulse is combinational from registers so the consumer can act on it.
module sync_edge_detect (
    input  logic CLK,
    input  logic RST_N,
    input  logic sync_in,
    output logic rise
);

    logic sync_ff1, sync_ff2, sync_ff3;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            sync_ff1 <= 1'b0;
            sync_ff2 <= 1'b0;
            sync_ff3 <= 1'b0;
        end else begin
            sync_ff1 <= sync_in;
            sync_ff2 <= sync_ff1;
            sync_ff3 <= sync_ff2;
        end
    end

    assign rise = sync_ff2 & ~sync_ff3;

endmodule

// File: rtl/sync_time_keeper.sv
// Local system-time counter disciplined to the ECAT_SYNC pulse train: arm/load,
// slew correction by tick insert/skip, hard-jump fallback, lock status and flywheel.
module sync_time_keeper
    import sync_pkg::*;
#(
    parameter int TIME_W      = DEF_TIME_W,
    parameter int PERIOD_W    = DEF_PERIOD_W,
    parameter int ERR_W       = DEF_ERR_W,
    parameter int ADJ_SPACING = DEF_ADJ_SPACING,
    parameter int JUMP_THRESH = DEF_JUMP_THRESH,
    parameter int LOCK_THRESH = DEF_LOCK_THRESH,
    parameter int LOCK_COUNT  = DEF_LOCK_COUNT
) (
    input  logic                    CLK,
    input  logic                    RST_N,
    input  logic                    SET,
    input  logic [TIME_W-1:0]       SET_TIME,
    input  logic [PERIOD_W-1:0]     SYNC_PERIOD,
    input  logic                    ECAT_SYNC,
    output logic [TIME_W-1:0]       SYS_TIME,
    output logic                    SYNC_PULSE,
    output logic signed [ERR_W-1:0] PHASE_ERR,
    output logic                    LOCKED
);

    localparam int ADJ_CNT_W = $clog2(ADJ_SPACING + 1);
    localparam int LCNT_W    = $clog2(LOCK_COUNT + 1);
    localparam logic [ADJ_CNT_W-1:0] ADJ_LAST  = ADJ_CNT_W'(ADJ_SPACING - 1);
    localparam logic [LCNT_W-1:0]    LOCK_FULL = LCNT_W'(LOCK_COUNT);

    localparam logic signed [TIME_W:0] JUMP_POS  = (TIME_W+1)'(JUMP_THRESH);
    localparam logic signed [TIME_W:0] JUMP_NEG  = -JUMP_POS;
    localparam logic signed [TIME_W:0] LOCK_POS  = (TIME_W+1)'(LOCK_THRESH);
    localparam logic signed [TIME_W:0] LOCK_NEG  = -LOCK_POS;
    localparam logic signed [TIME_W:0] ERR_MAX_W =
        $signed({{(TIME_W+2-ERR_W){1'b0}}, {(ERR_W-1){1'b1}}});
    localparam logic signed [TIME_W:0] ERR_MIN_W =
        $signed({{(TIME_W+2-ERR_W){1'b1}}, {(ERR_W-1){1'b0}}});

    function automatic logic signed [ERR_W-1:0] sat_err(input logic signed [TIME_W:0] v);
        if (v > ERR_MAX_W)
            sat_err = $signed({1'b0, {(ERR_W-1){1'b1}}});
        else if (v < ERR_MIN_W)
            sat_err = $signed({1'b1, {(ERR_W-1){1'b0}}});
        else
            sat_err = $signed(v[ERR_W-1:0]);
    endfunction

    sync_state_e              state;
    logic [TIME_W-1:0]        sys_time, exp_time, set_time_q;
    logic [PERIOD_W-1:0]      period_q;
    logic signed [ERR_W-1:0]  pending;
    logic [ADJ_CNT_W-1:0]     adj_cnt;
    logic [LCNT_W-1:0]        lock_cnt;
    logic [PERIOD_W:0]        fw_cnt;
    logic                     sync_pulse_q, locked_q;
    logic signed [ERR_W-1:0]  phase_err_q;
    logic signed [ERR_W-1:0]  err_p0;
    logic                     vld_p0;

    logic                     edge_rise;
    logic [TIME_W-1:0]        ts, diff;
    logic signed [TIME_W:0]   err_wide;
    logic signed [ERR_W-1:0]  err_sat;
    logic                     is_jump, in_lock, do_corr, fw_fire;
    logic [PERIOD_W:0]        fw_inc, fw_thresh;

    sync_edge_detect u_edge (
        .CLK     (CLK),
        .RST_N   (RST_N),
        .sync_in (ECAT_SYNC),
        .rise    (edge_rise)
    );

    // ts is the value SYS_TIME would show in the pulse cycle had no jump been made;
    // the modular difference is sign-extended so errors stay small across a wrap.
    assign ts       = sys_time + TIME_W'(1);
    assign diff     = ts - exp_time;
    assign err_wide = $signed({diff[TIME_W-1], diff});
    assign err_sat  = sat_err(err_wide);
    assign is_jump  = (err_wide > JUMP_POS) || (err_wide < JUMP_NEG);
    assign in_lock  = (err_wide <= LOCK_POS) && (err_wide >= LOCK_NEG);

    assign fw_inc    = fw_cnt + (PERIOD_W+1)'(1);
    assign fw_thresh = {1'b0, period_q} + {2'b00, period_q[PERIOD_W-1:1]};
    assign fw_fire   = (state == ST_TRACK) && !edge_rise && !SET && (fw_inc == fw_thresh);
    assign do_corr   = (state == ST_TRACK) && !edge_rise && !SET &&
                       (adj_cnt == ADJ_LAST) && (pending != '0);

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state        <= ST_IDLE;
            sys_time     <= '0;
            exp_time     <= '0;
            set_time_q   <= '0;
            period_q     <= '0;
            pending      <= '0;
            adj_cnt      <= '0;
            lock_cnt     <= '0;
            fw_cnt       <= '0;
            sync_pulse_q <= 1'b0;
            locked_q     <= 1'b0;
            phase_err_q  <= '0;
            err_p0       <= '0;
            vld_p0       <= 1'b0;
        end else begin
            sync_pulse_q <= edge_rise;
            vld_p0       <= 1'b0;
            sys_time     <= sys_time + TIME_W'(1);

            // p0 -> outputs: error and lock status land one cycle after the pulse
            if (vld_p0) begin
                phase_err_q <= err_p0;
                locked_q    <= (lock_cnt == LOCK_FULL);
            end

            if (do_corr) begin
                adj_cnt <= '0;
                if (!pending[ERR_W-1]) begin
                    sys_time <= sys_time + TIME_W'(2);
                    pending  <= pending - ERR_W'(1);
                end else begin
                    sys_time <= sys_time;
                    pending  <= pending + ERR_W'(1);
                end
            end else if (adj_cnt != ADJ_LAST) begin
                adj_cnt <= adj_cnt + ADJ_CNT_W'(1);
            end

            if (SET) begin
                state      <= ST_ARMED;
                set_time_q <= SET_TIME;
                period_q   <= SYNC_PERIOD;
                pending    <= '0;
                lock_cnt   <= '0;
                locked_q   <= 1'b0;
                fw_cnt     <= '0;
            end else if (edge_rise && state == ST_ARMED) begin
                sys_time <= set_time_q;
                exp_time <= set_time_q + TIME_W'(period_q);
                err_p0   <= '0;
                vld_p0   <= 1'b1;
                fw_cnt   <= '0;
                state    <= ST_TRACK;
            end else if (edge_rise && state == ST_TRACK) begin
                exp_time <= exp_time + TIME_W'(period_q);
                err_p0   <= err_sat;
                vld_p0   <= 1'b1;
                fw_cnt   <= '0;
                if (is_jump) begin
                    sys_time <= exp_time;
                    pending  <= '0;
                    lock_cnt <= '0;
                end else begin
                    pending <= -err_sat;
                    if (in_lock)
                        lock_cnt <= (lock_cnt == LOCK_FULL) ? lock_cnt : lock_cnt + LCNT_W'(1);
                    else
                        lock_cnt <= '0;
                end
            end else if (fw_fire) begin
                // missing pulse: advance the expectation by one period and keep counting
                exp_time <= exp_time + TIME_W'(period_q);
                fw_cnt   <= fw_inc - {1'b0, period_q};
                lock_cnt <= '0;
                locked_q <= 1'b0;
            end else if (state == ST_TRACK) begin
                fw_cnt <= fw_inc;
            end
        end
    end

    assign SYS_TIME   = sys_time;
    assign SYNC_PULSE = sync_pulse_q;
    assign PHASE_ERR  = phase_err_q;
    assign LOCKED     = locked_q;

endmodule
